dmem_port_arbiter: RTL and testbench

- Sequences the single-ported data memory between two requesters:
  - load issue from the memory functional unit;
  - committed-store writeback from the LSQ head.
- Owns the load-in-flight tracking: read-latency counter, destination phys reg / ROB tag capture, and squash on mispredict.
- Returns load results on a done/pd/rob/data bus that feeds CDB arbitration.
- Prevents stores from being starved by a continuous load stream, and loads by a store burst.

---
 rtl/dmem_port_arbiter_pkg.sv | 25 ++
 rtl/dmem_port_arbiter_rob_age_cmp.sv | 23 ++
 rtl/dmem_port_arbiter.sv | 239 +++++++++++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types and constants for the data-memory port arbiter and the
// ROB age comparator reused by the LSQ and ROB flush logic.
package dmem_port_arbiter_pkg;

    localparam int unsigned ROB_TAG_W = 5;
    localparam int unsigned PREG_W    = 7;
    localparam int unsigned XLEN      = 32;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LD_WAIT = 2'd1,
        LD_RESP = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic                 valid;
        logic [PREG_W-1:0]    pd;
        logic [ROB_TAG_W-1:0] rob;
        logic [XLEN-1:0]      data;
    } mem_resp_t;

endpackage

// File: rtl/dmem_port_arbiter_rob_age_cmp.sv
// rob_age_cmp: reports whether ROB tag a is younger than tag b, with age
// measured from the current ROB head in modulo-32 arithmetic.
//   a_tag, b_tag : ROB tags to compare
//   head         : current ROB head tag
//   a_younger    : 1 when age(a_tag) > age(b_tag)
module rob_age_cmp
    import dmem_port_arbiter_pkg::*;
(
    input  logic [ROB_TAG_W-1:0] a_tag,
    input  logic [ROB_TAG_W-1:0] b_tag,
    input  logic [ROB_TAG_W-1:0] head,
    output logic                 a_younger
);

    logic [ROB_TAG_W-1:0] age_a;
    logic [ROB_TAG_W-1:0] age_b;

    // Subtraction wraps naturally in ROB_TAG_W bits, so head > tag is handled.
    assign age_a     = a_tag - head;
    assign age_b     = b_tag - head;
    assign a_younger = (age_a > age_b);

endmodule

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares the single-ported data memory between load
// issue and committed-store writeback, tracks the one in-flight load
// (latency counter, pd/rob capture, mispredict squash) and returns the
// load result towards CDB arbitration.
//   ld_*       : load request / grant from the memory functional unit
//   st_*       : retired store at LSQ head / grant (LSQ pops head)
//   mispredict : branch flush with mispredict_tag, rob_head for ages
//   mem_*      : memory port (mem_rdata valid RD_LAT cycles after a read)
//   resp_*     : load result, one cycle pulse on resp_valid
//   busy       : load in flight
// Optional build macro DMEM_ARB_PERF_EN adds perf_ld_cnt, perf_st_cnt,
// perf_conflict_cnt and perf_squash_cnt.
module dmem_port_arbiter
    import dmem_port_arbiter_pkg::*;
#(
    parameter int unsigned RD_LAT     = 2,
    parameter int unsigned STARVE_MAX = 4
)
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ld_req,
    input  logic [XLEN-1:0]      ld_addr,
    input  logic [PREG_W-1:0]    ld_pd,
    input  logic [ROB_TAG_W-1:0] ld_rob,
    output logic                 ld_gnt,
    input  logic                 st_req,
    input  logic [XLEN-1:0]      st_addr,
    input  logic [XLEN-1:0]      st_data,
    output logic                 st_gnt,
    input  logic                 mispredict,
    input  logic [ROB_TAG_W-1:0] mispredict_tag,
    input  logic [ROB_TAG_W-1:0] rob_head,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [XLEN-1:0]      mem_addr,
    output logic [XLEN-1:0]      mem_wdata,
    input  logic [XLEN-1:0]      mem_rdata,
    output logic                 resp_valid,
    output logic [PREG_W-1:0]    resp_pd,
    output logic [ROB_TAG_W-1:0] resp_rob,
    output logic [XLEN-1:0]      resp_data,
    output logic                 busy
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [31:0]          perf_ld_cnt,
    output logic [31:0]          perf_st_cnt,
    output logic [31:0]          perf_conflict_cnt,
    output logic [15:0]          perf_squash_cnt
`endif
);

    localparam int unsigned CNT_W = 3;
    localparam int unsigned STV_W = $clog2(STARVE_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LAT - 1);
    localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_MAX);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_WAIT = LD_WAIT;
    localparam logic [1:0] ST_RESP = LD_RESP;

    // A single-cycle read latency skips the wait state entirely.
    localparam logic [1:0] ST_AFTER_LD = (RD_LAT == 1) ? ST_RESP : ST_WAIT;

    logic [1:0]           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [PREG_W-1:0]    cap_pd_q, cap_pd_d;
    logic [ROB_TAG_W-1:0] cap_rob_q, cap_rob_d;
    logic [STV_W-1:0]     ld_starve_q, ld_starve_d;
    logic [STV_W-1:0]     st_starve_q, st_starve_d;
    logic                 busy_q, busy_d;
    logic                 resp_valid_q, resp_valid_d;
    logic [PREG_W-1:0]    resp_pd_q, resp_pd_d;
    logic [ROB_TAG_W-1:0] resp_rob_q, resp_rob_d;

    logic      rob_younger_c;
    logic      squash_c;
    logic      resp_cycle_c;
    logic      ld_ok_c;
    logic      st_ok_c;
    logic      ld_win_c;
    logic      st_win_c;
    mem_resp_t resp_c;

    rob_age_cmp u_age_cmp (
        .a_tag     (cap_rob_q),
        .b_tag     (mispredict_tag),
        .head      (rob_head),
        .a_younger (rob_younger_c)
    );

    // Arbitration: load by default, store when load absent or store starved.
    // The response cycle is the counter-expiry cycle: rdata is being returned,
    // so a store may not use the port then.
    always_comb begin
        resp_cycle_c = (state_q == ST_RESP);
        ld_ok_c  = !reset && ld_req && !mispredict
                   && ((state_q == ST_IDLE) || resp_cycle_c);
        st_ok_c  = !reset && st_req && !resp_cycle_c;
        st_win_c = st_ok_c && (!ld_ok_c || (st_starve_q == STV_MAX));
        ld_win_c = ld_ok_c && !st_win_c;
        squash_c = mispredict && (state_q == ST_WAIT) && rob_younger_c;
    end

    // Memory port and grants follow the arbitration combinationally.
    always_comb begin
        ld_gnt    = ld_win_c;
        st_gnt    = st_win_c;
        mem_en    = ld_win_c || st_win_c;
        mem_we    = st_win_c;
        mem_addr  = '0;
        mem_wdata = '0;
        if (st_win_c) begin
            mem_addr  = st_addr;
            mem_wdata = st_data;
        end else if (ld_win_c) begin
            mem_addr  = ld_addr;
        end
    end

    // Next-state, capture and response logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cap_pd_d  = cap_pd_q;
        cap_rob_d = cap_rob_q;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_IDLE;
            end
            ST_WAIT: begin
                if (squash_c) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q <= CNT_W'(1)) begin
                    state_d = ST_RESP;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // A load grant (from IDLE or back-to-back from RESP) starts a new read.
        if (ld_win_c) begin
            state_d   = ST_AFTER_LD;
            cnt_d     = CNT_LOAD;
            cap_pd_d  = ld_pd;
            cap_rob_d = ld_rob;
        end

        busy_d       = (state_d != ST_IDLE);
        resp_valid_d = (state_d == ST_RESP);
        resp_pd_d    = resp_valid_d ? cap_pd_d  : '0;
        resp_rob_d   = resp_valid_d ? cap_rob_d : '0;

        ld_starve_d = ld_starve_q;
        if (ld_win_c) begin
            ld_starve_d = '0;
        end else if (ld_req && (ld_starve_q != STV_MAX)) begin
            ld_starve_d = ld_starve_q + STV_W'(1);
        end

        st_starve_d = st_starve_q;
        if (st_win_c) begin
            st_starve_d = '0;
        end else if (st_req && (st_starve_q != STV_MAX)) begin
            st_starve_d = st_starve_q + STV_W'(1);
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            cap_pd_q     <= '0;
            cap_rob_q    <= '0;
            ld_starve_q  <= '0;
            st_starve_q  <= '0;
            busy_q       <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_pd_q    <= '0;
            resp_rob_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cap_pd_q     <= cap_pd_d;
            cap_rob_q    <= cap_rob_d;
            ld_starve_q  <= ld_starve_d;
            st_starve_q  <= st_starve_d;
            busy_q       <= busy_d;
            resp_valid_q <= resp_valid_d;
            resp_pd_q    <= resp_pd_d;
            resp_rob_q   <= resp_rob_d;
        end
    end

    // Read data arrives from the memory during the response cycle itself.
    always_comb begin
        resp_c.valid = resp_valid_q;
        resp_c.pd    = resp_pd_q;
        resp_c.rob   = resp_rob_q;
        resp_c.data  = resp_valid_q ? mem_rdata : '0;
    end

    assign resp_valid = resp_c.valid;
    assign resp_pd    = resp_c.pd;
    assign resp_rob   = resp_c.rob;
    assign resp_data  = resp_c.data;
    assign busy       = busy_q;

`ifdef DMEM_ARB_PERF_EN
    // Event counters, free-running and wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_ld_cnt       <= '0;
            perf_st_cnt       <= '0;
            perf_conflict_cnt <= '0;
            perf_squash_cnt   <= '0;
        end else begin
            perf_ld_cnt       <= perf_ld_cnt + 32'(ld_win_c);
            perf_st_cnt       <= perf_st_cnt + 32'(st_win_c);
            perf_conflict_cnt <= perf_conflict_cnt + 32'(ld_req && st_req);
            perf_squash_cnt   <= perf_squash_cnt + 16'(squash_c);
        end
    end
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: a transaction-level model
// (one outstanding load with a known return cycle, a store-starvation
// count) is compared against the DUT every cycle, with directed scenarios
// pinned by literal expectations followed by randomized traffic.
module tb_dmem_port_arbiter;

    localparam int unsigned RD_LAT     = 2;
    localparam int unsigned STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ld_req = 1'b0;
    logic [31:0] ld_addr = '0;
    logic [6:0]  ld_pd = '0;
    logic [4:0]  ld_rob = '0;
    logic        ld_gnt;
    logic        st_req = 1'b0;
    logic [31:0] st_addr = '0;
    logic [31:0] st_data = '0;
    logic        st_gnt;
    logic        mispredict = 1'b0;
    logic [4:0]  mispredict_tag = '0;
    logic [4:0]  rob_head = '0;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        resp_valid;
    logic [6:0]  resp_pd;
    logic [4:0]  resp_rob;
    logic [31:0] resp_data;
    logic        busy;
`ifdef DMEM_ARB_PERF_EN
    logic [31:0] perf_ld_cnt;
    logic [31:0] perf_st_cnt;
    logic [31:0] perf_conflict_cnt;
    logic [15:0] perf_squash_cnt;
`endif

    always #5 clk = ~clk;

    dmem_port_arbiter #(.RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)) dut (
        .clk            (clk),
        .reset          (reset),
        .ld_req         (ld_req),
        .ld_addr        (ld_addr),
        .ld_pd          (ld_pd),
        .ld_rob         (ld_rob),
        .ld_gnt         (ld_gnt),
        .st_req         (st_req),
        .st_addr        (st_addr),
        .st_data        (st_data),
        .st_gnt         (st_gnt),
        .mispredict     (mispredict),
        .mispredict_tag (mispredict_tag),
        .rob_head       (rob_head),
        .mem_en         (mem_en),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .resp_valid     (resp_valid),
        .resp_pd        (resp_pd),
        .resp_rob       (resp_rob),
        .resp_data      (resp_data),
        .busy           (busy)
`ifdef DMEM_ARB_PERF_EN
        ,
        .perf_ld_cnt       (perf_ld_cnt),
        .perf_st_cnt       (perf_st_cnt),
        .perf_conflict_cnt (perf_conflict_cnt),
        .perf_squash_cnt   (perf_squash_cnt)
`endif
    );

    // Environment memory: 64 words, reads return RD_LAT cycles after issue.
    logic [31:0] mem     [0:63];
    logic [31:0] rd_pipe [0:7];
    assign mem_rdata = rd_pipe[RD_LAT-1];

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 64; i++) mem[i] <= {16'hC0DE, 8'(i), ~8'(i)};
            mem[16] <= 32'hDEADBEEF;
            for (int i = 0; i < 8; i++) rd_pipe[i] <= 32'hBADC0FFE;
        end else begin
            if (mem_en && mem_we) mem[mem_addr[7:2]] <= mem_wdata;
            rd_pipe[0] <= (mem_en && !mem_we) ? mem[mem_addr[7:2]] : 32'hBADC0FFE;
            for (int i = 1; i < 8; i++) rd_pipe[i] <= rd_pipe[i-1];
        end
    end

    int n_err = 0;
    int n_chk = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model state.
    bit          m_inf = 1'b0;
    int          m_ret = 0;
    logic [6:0]  m_pd;
    logic [4:0]  m_rob;
    logic [31:0] m_data;
    int          m_st_starve = 0;
    int          cyc = 0;
    bit          e_ld = 1'b0;
    bit          e_st = 1'b0;

    function automatic logic [4:0] age(input logic [4:0] t, input logic [4:0] h);
        age = t - h;
    endfunction

    // Evaluate the model for the current cycle, compare, then advance it.
    task automatic model_cmp();
        bit resp_cyc, ld_el, st_el;
        if (reset) begin
            m_inf = 1'b0; m_st_starve = 0; e_ld = 1'b0; e_st = 1'b0;
            return;
        end
        resp_cyc = m_inf && (cyc == m_ret);
        ld_el = ld_req && !mispredict && (!m_inf || resp_cyc);
        st_el = st_req && !resp_cyc;
        e_st  = st_el && (!ld_el || m_st_starve >= STARVE_MAX);
        e_ld  = ld_el && !e_st;

        chk("ld_gnt", 32'(ld_gnt), 32'(e_ld));
        chk("st_gnt", 32'(st_gnt), 32'(e_st));
        chk("mem_en", 32'(mem_en), 32'(e_ld || e_st));
        chk("mem_we", 32'(mem_we), 32'(e_st));
        if (e_ld) chk("mem_addr_ld", mem_addr, ld_addr);
        if (e_st) begin
            chk("mem_addr_st", mem_addr, st_addr);
            chk("mem_wdata", mem_wdata, st_data);
        end
        chk("busy", 32'(busy), 32'(m_inf));
        chk("resp_valid", 32'(resp_valid), 32'(resp_cyc));
        if (resp_cyc) begin
            chk("resp_pd", 32'(resp_pd), 32'(m_pd));
            chk("resp_rob", 32'(resp_rob), 32'(m_rob));
            chk("resp_data", resp_data, m_data);
        end

        if (e_st) m_st_starve = 0;
        else if (st_req && m_st_starve < STARVE_MAX) m_st_starve++;
        if (m_inf && !resp_cyc && mispredict
            && age(m_rob, rob_head) > age(mispredict_tag, rob_head)) m_inf = 1'b0;
        if (resp_cyc) m_inf = 1'b0;
        if (e_ld) begin
            m_inf = 1'b1; m_ret = cyc + RD_LAT;
            m_pd = ld_pd; m_rob = ld_rob; m_data = mem[ld_addr[7:2]];
        end
        cyc++;
    endtask

    task automatic cyc_eval();
        @(negedge clk);
        model_cmp();
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ld(input logic [31:0] a, input logic [6:0] pd, input logic [4:0] rob);
        ld_req = 1'b1; ld_addr = a; ld_pd = pd; ld_rob = rob;
    endtask

    task automatic set_st(input logic [31:0] a, input logic [31:0] d);
        st_req = 1'b1; st_addr = a; st_data = d;
    endtask

    task automatic idle(input int n);
        ld_req = 1'b0; st_req = 1'b0; mispredict = 1'b0;
        for (int i = 0; i < n; i++) begin
            cyc_eval();
            adv();
        end
    endtask

    int st_seen;

    initial begin
        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_resp_valid", 32'(resp_valid), 0);
        chk("rst_mem_en", 32'(mem_en), 0);
        chk("rst_resp_data", resp_data, 0);
        model_cmp();
        @(posedge clk); #1;
        reset = 1'b0;

        // Lone load.
        set_ld(32'h40, 7'd12, 5'd5);
        cyc_eval();
        chk("lone_gnt", 32'(ld_gnt), 1);
        chk("lone_addr", mem_addr, 32'h40);
        adv(); ld_req = 1'b0;
        cyc_eval();
        chk("lone_busy1", 32'(busy), 1);
        adv();
        cyc_eval();
        chk("lone_rv", 32'(resp_valid), 1);
        chk("lone_pd", 32'(resp_pd), 12);
        chk("lone_rob", 32'(resp_rob), 5);
        chk("lone_data", resp_data, 32'hDEADBEEF);
        adv();
        cyc_eval();
        chk("lone_busy3", 32'(busy), 0);
        adv();
        idle(2);

        // Simultaneous load and store; store blocked in the return cycle.
        set_ld(32'h44, 7'd3, 5'd2);
        set_st(32'h48, 32'h1234);
        cyc_eval();
        chk("sim_ld_first", 32'(ld_gnt), 1);
        chk("sim_st_wait0", 32'(st_gnt), 0);
        adv(); ld_req = 1'b0;
        cyc_eval();
        chk("sim_st_in_wait", 32'(st_gnt), 1);
        chk("sim_st_addr", mem_addr, 32'h48);
        adv();
        set_st(32'h4C, 32'h5678);
        cyc_eval();
        chk("sim_st_blocked", 32'(st_gnt), 0);
        chk("sim_resp", 32'(resp_valid), 1);
        chk("sim_resp_data", resp_data, 32'hC0DE11EE);
        adv();
        cyc_eval();
        chk("sim_st_after", 32'(st_gnt), 1);
        adv();
        idle(2);

        // Store against a continuous back-to-back load stream.
        st_seen = 0;
        set_st(32'h80, 32'hCAFE0001);
        set_ld(32'h10, 7'd1, 5'd1);
        for (int i = 1; i <= 8; i++) begin
            cyc_eval();
            if (st_gnt && st_seen == 0) st_seen = i;
            adv();
            if (e_st) st_req = 1'b0;
            if (e_ld) set_ld(32'(i * 4), 7'(i), 5'(i));
        end
        chk("starve_bound", 32'(st_seen >= 1 && st_seen <= 5), 1);
        idle(3);

        // Squash of a younger load with ROB wrap.
        rob_head = 5'd30;
        set_ld(32'h60, 7'd20, 5'd1);
        cyc_eval();
        chk("sq_gnt", 32'(ld_gnt), 1);
        adv(); ld_req = 1'b0;
        mispredict = 1'b1; mispredict_tag = 5'd31;
        cyc_eval();
        chk("sq_busy_hold", 32'(busy), 1);
        adv(); mispredict = 1'b0;
        cyc_eval();
        chk("sq_no_resp", 32'(resp_valid), 0);
        chk("sq_busy_drop", 32'(busy), 0);
        adv();
        idle(2);

        // Older load survives a mispredict.
        rob_head = 5'd2;
        set_ld(32'h64, 7'd33, 5'd3);
        cyc_eval();
        adv(); ld_req = 1'b0;
        mispredict = 1'b1; mispredict_tag = 5'd6;
        cyc_eval();
        adv(); mispredict = 1'b0;
        cyc_eval();
        chk("old_rv", 32'(resp_valid), 1);
        chk("old_pd", 32'(resp_pd), 33);
        chk("old_rob", 32'(resp_rob), 3);
        chk("old_data", resp_data, 32'hC0DE19E6);
        adv();
        idle(2);

        // Asynchronous reset while a load is waiting.
        rob_head = 5'd0;
        set_ld(32'h50, 7'd9, 5'd4);
        cyc_eval();
        adv(); ld_req = 1'b0;
        #2 reset = 1'b1;
        set_ld(32'h54, 7'd8, 5'd7);
        set_st(32'h58, 32'h1);
        #1;
        chk("arst_busy", 32'(busy), 0);
        chk("arst_mem_en", 32'(mem_en), 0);
        chk("arst_gnt", 32'(ld_gnt | st_gnt), 0);
        chk("arst_rv", 32'(resp_valid), 0);
        cyc_eval();
        adv();
        ld_req = 1'b0; st_req = 1'b0;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc_eval();
            chk("arst_no_resp", 32'(resp_valid), 0);
            adv();
        end

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            if (!ld_req && $urandom_range(0, 2) == 0)
                set_ld(32'($urandom_range(0, 63)) << 2, 7'($urandom_range(0, 127)),
                       5'($urandom_range(0, 31)));
            if (!st_req && $urandom_range(0, 3) == 0)
                set_st(32'($urandom_range(0, 63)) << 2, $urandom);
            mispredict     = ($urandom_range(0, 5) == 0);
            mispredict_tag = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 7) == 0) rob_head = 5'($urandom_range(0, 31));
            cyc_eval();
            adv();
            if (e_ld) ld_req = 1'b0;
            if (e_st) st_req = 1'b0;
        end
        idle(4);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
